// File: rtl/seg_pkg.sv
// Shared definitions for the eight-digit seven-segment scan controller.
//   scan_state_e : scan FSM states (IDLE / BLANK / SHOW)
//   NUM_DIGITS   : number of digits in the bank and the scan
//   EN_ALL_OFF   : active-low enable byte with every digit dark
//   en_pattern() : digit index -> one-cold enable byte (digit k drives en[7-k] low)
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  localparam int NUM_DIGITS = 8;
  localparam logic [7:0] EN_ALL_OFF = 8'hFF;

  function automatic logic [7:0] en_pattern(input logic [2:0] idx);
    return ~(8'h80 >> idx);
  endfunction

endpackage

// File: rtl/seg_wr_arb.sv
// Two-port round-robin write arbiter for the digit bank.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   a_valid / a_ready  : host port request / grant
//   b_valid / b_ready  : local port request / grant
// Handshake: a write on a port completes in any cycle where its valid and
// ready are both high. Ready is combinational from valid and the priority
// pointer, never depends on ready of the other port, and is held low while
// reset is asserted. At most one ready is high per cycle.
module seg_wr_arb (
  input  logic i_clk,
  input  logic i_rst,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_ready,
  output logic b_ready
);

  // ptr_b_q = 0 favours port A, 1 favours port B
  logic ptr_b_q;
  logic ptr_b_d;

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!i_rst) begin
      a_ready = a_valid && (!b_valid || !ptr_b_q);
      b_ready = b_valid && (!a_valid || ptr_b_q);
    end
  end

  // After any grant the pointer favours the port that was not served;
  // with no grant it holds.
  always_comb begin
    ptr_b_d = ptr_b_q;
    if (a_ready) begin
      ptr_b_d = 1'b1;
    end else if (b_ready) begin
      ptr_b_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_b_q <= 1'b0;
    end else begin
      ptr_b_q <= ptr_b_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed eight-digit seven-segment display scan controller.
//   SCAN_DIV, BLANK_CYC : cycles per digit slot / leading blank cycles per slot
//   i_clk, i_rst        : clock, synchronous active-high reset
//   a_* / b_*           : host and local write ports into the 8 x 8-bit bank
//   i_scan_en           : run scanning (low forces IDLE with display dark)
//   i_bright            : PWM duty level, digit lit while pwm <= i_bright
//   data                : registered segment pattern of the active digit
//   en                  : registered active-low digit enables (one-cold or FF)
//   frame_done          : high during the last SHOW cycle of digit 7
//   dbg_state           : current scan FSM state
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 125000,
  parameter int BLANK_CYC = 1250
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_addr,
  input  logic [7:0]  a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [2:0]  b_addr,
  input  logic [7:0]  b_data,
  input  logic        i_scan_en,
  input  logic [3:0]  i_bright,
  output logic [7:0]  data,
  output logic [7:0]  en,
  output logic        frame_done,
  output scan_state_e dbg_state
);

  localparam int CNT_W = ($clog2(SCAN_DIV) > 17) ? $clog2(SCAN_DIV) : 17;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);

  // Digit bank and its write path
  logic [7:0] bank_q [NUM_DIGITS];
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;

  seg_wr_arb u_arb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .a_ready (a_ready),
    .b_ready (b_ready)
  );

  assign wr_en   = a_ready || b_ready;
  assign wr_addr = a_ready ? a_addr : b_addr;
  assign wr_data = a_ready ? a_data : b_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        bank_q[i] <= 8'hFF;
      end
    end else if (wr_en) begin
      bank_q[wr_addr] <= wr_data;
    end
  end

  // Scan FSM. The slot counter runs 0..SCAN_DIV-1 across one digit slot:
  // BLANK covers 0..BLANK_CYC-1, SHOW covers the rest.
  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       pwm_q, pwm_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       en_q, en_d;
  logic             fd_q, fd_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pwm_d   = pwm_q;
    data_d  = data_q;
    en_d    = EN_ALL_OFF;
    fd_d    = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
      BLANK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          data_d  = bank_q[idx_q];
        end
      end
      SHOW: begin
        if (cnt_q == SLOT_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Dropping scan enable overrides everything, including a pending latch.
    if (!i_scan_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      pwm_d   = '0;
      data_d  = data_q;
    end

    // Outputs are registered, so they are decoded from the next state.
    if (state_d == SHOW) begin
      pwm_d = pwm_q + 4'd1;
      if (pwm_q <= i_bright) begin
        en_d = en_pattern(idx_d);
      end
      fd_d = (idx_d == 3'd7) && (cnt_d == SLOT_LAST);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pwm_q   <= '0;
      data_q  <= 8'hFF;
      en_q    <= EN_ALL_OFF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pwm_q   <= pwm_d;
      data_q  <= data_d;
      en_q    <= en_d;
      fd_q    <= fd_d;
    end
  end

  assign data       = data_q;
  assign en         = en_q;
  assign frame_done = fd_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int SD = 16;
  localparam int BC = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0, scan_en = 1'b0;
  logic [2:0]  a_addr = '0, b_addr = '0;
  logic [7:0]  a_data = '0, b_data = '0;
  logic [3:0]  bright = 4'hF;
  logic        a_ready, b_ready, frame_done;
  logic [7:0]  data, en;
  scan_state_e dbg_state;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .i_clk(clk), .i_rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .i_scan_en(scan_en), .i_bright(bright),
    .data(data), .en(en), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [16:0] exp_q[$];   // {frame_done, data, en} for the coming cycle
  logic s_a_ready, s_b_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Scan position is the cycle count since scanning started; everything else
  // is derived arithmetically from it.
  logic [7:0] bank_m [8];
  bit         ptr_b_m = 1'b0;
  bit         running_m = 1'b0;
  int         t_m = 0;
  logic [7:0] shown_m = 8'hFF;

  task automatic model_edge(output bit ga, output bit gb);
    int off, slot, shows;
    logic [7:0] e_en;
    logic e_fd;
    ga = !rst && a_valid && (!b_valid || !ptr_b_m);
    gb = !rst && b_valid && !ga;
    if (rst) begin
      for (int i = 0; i < 8; i++) bank_m[i] = 8'hFF;
      ptr_b_m = 1'b0; running_m = 1'b0; t_m = 0; shown_m = 8'hFF;
      exp_q.push_back({1'b0, 8'hFF, 8'hFF});
    end else begin
      if (!scan_en) running_m = 1'b0;
      else if (!running_m) begin running_m = 1'b1; t_m = 0; end
      else t_m++;
      e_en = 8'hFF;
      e_fd = 1'b0;
      if (running_m) begin
        off  = t_m % SD;
        slot = t_m / SD;
        if (off == BC) shown_m = bank_m[slot % 8];
        if (off >= BC) begin
          shows = slot * (SD - BC) + off - BC;
          if ((shows % 16) <= int'(bright)) e_en = ~(8'h80 >> (slot % 8));
        end
        e_fd = (t_m % (8 * SD)) == (8 * SD - 1);
      end
      exp_q.push_back({e_fd, shown_m, e_en});
      if (ga) begin bank_m[a_addr] = a_data; ptr_b_m = 1'b1; end
      else if (gb) begin bank_m[b_addr] = b_data; ptr_b_m = 1'b0; end
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic cycle();
    bit ga, gb;
    logic [16:0] e;
    #1;
    s_a_ready = a_ready;
    s_b_ready = b_ready;
    model_edge(ga, gb);
    check("a_ready", a_ready, ga);
    check("b_ready", b_ready, gb);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got 0 expected 1 entries");
    end else begin
      e = exp_q.pop_front();
      check("en", en, e[7:0]);
      check("data", data, e[15:8]);
      check("frame_done", frame_done, e[16]);
      check("idle_state", dbg_state == IDLE, !running_m);
    end
  endtask

  task automatic wait_show(input int d);
    int n = 0;
    while (!(running_m && (t_m % SD) == BC && ((t_m / SD) % 8) == d) && n < 400) begin
      cycle();
      n++;
    end
    check("wait_show_bound", n < 400, 1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic       av; logic [2:0] aa; logic [7:0] ad;
    logic       bv; logic [2:0] ba; logic [7:0] bd;
    logic       ea; logic       eb;
  } vec_t;
  vec_t vecs[9];

  initial begin
    int fd_cnt, low_cnt, show_cnt, guard;

    for (int k = 0; k < 4; k++)
      vecs[k] = '{1'b1, 3'(k), 8'hA0 + 8'(k), 1'b1, 3'(k), 8'hB0 + 8'(k),
                  (k % 2) == 0, (k % 2) == 1};
    vecs[4] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h44, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 3'd5, 8'hA5, 1'b1, 3'd5, 8'hB5, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 3'd6, 8'h66, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 3'd1, 8'h77, 1'b0, 3'd2, 8'h88, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 3'd7, 8'hA7, 1'b1, 3'd7, 8'hB7, 1'b0, 1'b1};

    // reset
    @(negedge clk);
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_state", dbg_state, IDLE);
    check("rst_en", en, 8'hFF);
    check("rst_data", data, 8'hFF);
    check("rst_frame_done", frame_done, 0);

    // basic scan of the reset bank
    scan_en = 1'b1;
    fd_cnt = 0;
    for (int i = 0; i < 8 * SD; i++) begin
      cycle();
      if (i == 0)  check("s1_blank_en", en, 8'hFF);
      if (i == 3)  check("s1_blank_last", en, 8'hFF);
      if (i == 4)  check("s1_show_en", en, 8'h7F);
      if (i == 15) check("s1_show_last", en, 8'h7F);
      if (i == 16) check("s1_next_blank", en, 8'hFF);
      if (i == 20) check("s1_digit1", en, 8'hBF);
      if (i == 127) check("s1_frame_done", frame_done, 1);
      fd_cnt += int'(frame_done);
    end
    check("s1_frame_done_count", fd_cnt, 1);

    // arbitration table, display idle
    scan_en = 1'b0;
    cycle();
    for (int i = 0; i < 9; i++) begin
      a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
      cycle();
      check($sformatf("arb_a_%0d", i), s_a_ready, vecs[i].ea);
      check($sformatf("arb_b_%0d", i), s_b_ready, vecs[i].eb);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;

    // scan the written bank, then write digit 2 while it is shown
    scan_en = 1'b1;
    wait_show(0);
    check("bank0", data, 8'hA0);
    wait_show(1);
    check("bank1", data, 8'hB1);
    wait_show(2);
    check("bank2", data, 8'hA2);
    cycle();
    cycle();
    a_valid = 1'b1; a_addr = 3'd2; a_data = 8'hC0;
    cycle();
    a_valid = 1'b0;
    cycle();
    check("s3_data_hold", data, 8'hA2);
    wait_show(3);
    check("bank3", data, 8'hB3);
    wait_show(2);
    check("s3_data_new", data, 8'hC0);

    // brightness 3: lit on 4 of every 16 SHOW cycles
    bright = 4'd3;
    wait_show(4);
    low_cnt = 0; show_cnt = 0; guard = 0;
    while (show_cnt < 16 && guard < 64) begin
      if (dbg_state == SHOW) begin
        show_cnt++;
        if (en != 8'hFF) low_cnt++;
      end
      cycle();
      guard++;
    end
    check("s4_low_count", low_cnt, 4);
    bright = 4'hF;

    // drop scan enable mid-SHOW of digit 5, then restart
    wait_show(5);
    cycle();
    cycle();
    cycle();
    check("s5_mid_show", en, 8'hFB);
    scan_en = 1'b0;
    cycle();
    check("s5_off_en", en, 8'hFF);
    check("s5_off_state", dbg_state, IDLE);
    cycle();
    scan_en = 1'b1;
    cycle();
    check("s5_restart_state", dbg_state, BLANK);
    check("s5_restart_en", en, 8'hFF);
    for (int i = 0; i < BC; i++) cycle();
    check("s5_restart_digit0", en, 8'h7F);

    // reset during a granted write
    a_valid = 1'b1; a_addr = 3'd3; a_data = 8'h5A;
    cycle();
    rst = 1'b1;
    a_addr = 3'd6; a_data = 8'h96;
    cycle();
    check("s6_ready_in_rst", s_a_ready, 0);
    rst = 1'b0;
    a_valid = 1'b0;
    check("s6_en", en, 8'hFF);
    check("s6_data", data, 8'hFF);
    check("s6_state", dbg_state, IDLE);
    wait_show(6);
    check("s6_bank6", data, 8'hFF);
    wait_show(3);
    check("s6_bank3", data, 8'hFF);

    // randomized traffic against the model
    for (int i = 0; i < 1200; i++) begin
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      a_addr  = 3'($urandom_range(0, 7));
      b_addr  = 3'($urandom_range(0, 7));
      a_data  = 8'($urandom_range(0, 255));
      b_data  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 149) == 0) scan_en = ~scan_en;
      else if (!scan_en && $urandom_range(0, 7) == 0) scan_en = 1'b1;
      if ($urandom_range(0, 39) == 0) bright = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 399) == 0);
      cycle();
    end
    rst = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
